// File: rtl/cardrom_boot_seq.sv
// Boot-release sequencer: qualifies subsystem ready flags over a settle window, then
// requests ROM release and tracks the handoff. Optional forced release: CARDROM_BOOT_TIMEOUT_EN.
module cardrom_boot_seq #(
   parameter int unsigned NUM_READY      = 4,
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 54_000_000
) (
   input  logic                 clk_logic,
   input  logic                 system_reset_n,
   input  logic [NUM_READY-1:0] ready_i,
   input  logic [NUM_READY-1:0] ready_mask_i,
   input  logic                 rom_en_i,
   output logic                 req_rom_release_o,
   output logic                 boot_done_o,
   output logic                 timeout_o,
   output logic [2:0]           state_o,
   output logic [NUM_READY-1:0] ready_seen_o
);

   localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

   if (SETTLE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_chk
      $error("cardrom_boot_seq: SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_RELEASE = 3'd3,
      ST_HANDOFF = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   state_t              state_q;
   state_t              state_nxt;
   logic [SETTLE_W-1:0] settle_cnt_q;
   logic [SETTLE_W-1:0] settle_cnt_nxt;
   logic                all_ready;
   logic                timeout_hit;
   logic                forced_nxt;

   // Masked-off bits count as ready.
   assign all_ready = &(ready_i | ~ready_mask_i);

`ifdef CARDROM_BOOT_TIMEOUT_EN
   localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TIMEOUT_W-1:0] timeout_cnt_q;
   logic [TIMEOUT_W-1:0] timeout_cnt_nxt;
   logic                 in_hold;

   // Free-running across WAIT/SETTLE fallbacks; saturates at the limit.
   always_comb begin
      in_hold         = (state_q == ST_WAIT) || (state_q == ST_SETTLE);
      timeout_cnt_nxt = timeout_cnt_q;
      if (in_hold && (timeout_cnt_q != TIMEOUT_W'(TIMEOUT_CYCLES))) begin
         timeout_cnt_nxt = timeout_cnt_q + TIMEOUT_W'(1);
      end
      timeout_hit = in_hold && (timeout_cnt_nxt == TIMEOUT_W'(TIMEOUT_CYCLES));
   end

   always_ff @(posedge clk_logic) begin
      if (!system_reset_n) begin
         timeout_cnt_q <= '0;
      end else begin
         timeout_cnt_q <= timeout_cnt_nxt;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state logic; ROM-already-unmapped in WAIT outranks timeout, which outranks settling.
   always_comb begin
      state_nxt      = state_q;
      settle_cnt_nxt = settle_cnt_q;
      forced_nxt     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (!rom_en_i) begin
               state_nxt = ST_DONE;
            end else if (timeout_hit) begin
               state_nxt  = ST_RELEASE;
               forced_nxt = 1'b1;
            end else if (all_ready) begin
               state_nxt      = ST_SETTLE;
               settle_cnt_nxt = '0;
            end
         end
         ST_SETTLE: begin
            if (timeout_hit) begin
               state_nxt  = ST_RELEASE;
               forced_nxt = 1'b1;
            end else if (!all_ready) begin
               state_nxt      = ST_WAIT;
               settle_cnt_nxt = '0;
            end else if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES)) begin
               state_nxt = ST_RELEASE;
            end else begin
               settle_cnt_nxt = settle_cnt_q + SETTLE_W'(1);
            end
         end
         ST_RELEASE: begin
            state_nxt = ST_HANDOFF;
         end
         ST_HANDOFF: begin
            if (!rom_en_i) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_DONE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and outputs registered together; outputs decode the incoming state.
   always_ff @(posedge clk_logic) begin
      if (!system_reset_n) begin
         state_q           <= ST_IDLE;
         settle_cnt_q      <= '0;
         req_rom_release_o <= 1'b0;
         boot_done_o       <= 1'b0;
         timeout_o         <= 1'b0;
         ready_seen_o      <= '0;
      end else begin
         state_q           <= state_nxt;
         settle_cnt_q      <= settle_cnt_nxt;
         req_rom_release_o <= (state_nxt == ST_RELEASE) || (state_nxt == ST_HANDOFF);
         boot_done_o       <= boot_done_o || (state_nxt == ST_DONE);
         timeout_o         <= timeout_o || forced_nxt;
         ready_seen_o      <= ready_seen_o | (ready_i & ready_mask_i);
      end
   end

   assign state_o = 3'(state_q);

endmodule
